// File: rtl/fir_mac_sequencer.sv
// Sequencer for the transposed-form FIR MAC datapath: sample/accumulate strobes,
// double-buffered coefficient banks and result-valid tracking.
//
// state    | meaning
// IDLE     | no strobes; commits swap the active bank immediately
// RUN      | sample counter free-runs, strobe every DIV cycles
// STOPPING | finishing the current period, last strobe then IDLE
module fir_mac_sequencer #(
  parameter int DIV  = 40,
  parameter int NTAP = 10,
  parameter int CW   = 16
) (
  input  logic                 iClk_12M,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic                 iStop,
  input  logic                 iCoeffWe,
  input  logic [3:0]           iCoeffAddr,
  input  logic signed [CW-1:0] iCoeffData,
  input  logic                 iCoeffCommit,
  output logic [NTAP*CW-1:0]   oCoeffBus,
  output logic                 oEnSample_300k,
  output logic                 oEnAcc,
  output logic                 oMacValid,
  output logic                 oCommitAck,
  output logic                 oCoeffErr,
  output logic                 oBusy
);

  localparam int FW = $clog2(NTAP + 2);
  localparam logic [7:0]    CNT_LAST = 8'(DIV - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(NTAP + 1);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t              state, state_next;
  logic [7:0]          samp_cnt, cnt_next;
  logic [FW-1:0]       fill, fill_next;
  logic                pend, pend_next;
  logic                commit_req, swap, start_run, wr_ok;
  logic [NTAP*CW-1:0]  shadow, shadow_next;

  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    case (state)
      IDLE: begin
        if (iStart && !iStop) begin
          state_next = RUN;
          start_run  = 1'b1;
        end
      end
      RUN:      if (iStop) state_next = STOPPING;
      STOPPING: if (samp_cnt == CNT_LAST) state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    if (state_next == IDLE || start_run || samp_cnt == CNT_LAST) cnt_next = 8'd0;
    else                                                       cnt_next = samp_cnt + 8'd1;

    wr_ok       = iCoeffWe && (int'(iCoeffAddr) < NTAP);
    shadow_next = shadow;
    for (int k = 0; k < NTAP; k++) begin
      if (wr_ok && iCoeffAddr == 4'(k)) shadow_next[k*CW +: CW] = iCoeffData;
    end

    // In RUN/STOPPING the swap lands on the edge after the strobe cycle, so the
    // new bank becomes visible at count 0 and never splits a sample's products.
    commit_req = pend | iCoeffCommit;
    swap       = commit_req && (state == IDLE || samp_cnt == CNT_LAST);
    pend_next  = commit_req && !swap;

    if (start_run || swap)                      fill_next = '0;
    else if (oEnSample_300k && fill != FILL_MAX) fill_next = fill + 1'b1;
    else                                        fill_next = fill;
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state          <= IDLE;
      samp_cnt       <= 8'd0;
      fill           <= '0;
      pend           <= 1'b0;
      shadow         <= '0;
      oCoeffBus      <= '0;
      oEnSample_300k <= 1'b0;
      oEnAcc         <= 1'b0;
      oMacValid      <= 1'b0;
      oCommitAck     <= 1'b0;
      oCoeffErr      <= 1'b0;
      oBusy          <= 1'b0;
    end else begin
      state          <= state_next;
      samp_cnt       <= cnt_next;
      fill           <= fill_next;
      pend           <= pend_next;
      shadow         <= shadow_next;
      if (swap) oCoeffBus <= shadow_next;
      oEnSample_300k <= (state_next != IDLE) && (cnt_next == CNT_LAST);
      oEnAcc         <= (state_next != IDLE) && (cnt_next == CNT_LAST);
      oMacValid      <= (fill_next == FILL_MAX);
      oCommitAck     <= swap;
      oCoeffErr      <= iCoeffWe && !wr_ok;
      oBusy          <= (state_next != IDLE);
    end
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Control block for the 10-tap transposed-form multiply/add/shift MAC datapath.
- Generates the 300 kHz sample strobe and the accumulate enable from the 12 MHz clock.
- Owns a shadow/active coefficient bank pair, so software can rewrite taps without corrupting in-flight samples.
- Flags when the datapath output holds a result computed entirely with one coefficient set.
- Sits between the register/config interface and the MAC datapath; drives its enables and coefficient inputs.

Parameters:
- DIV, 40, 12 MHz clock cycles per sample period (12 MHz / 40 = 300 kHz); legal range 2..255.
- NTAP, 10, number of taps (coefficient count) in the MAC datapath.
- CW, 16, coefficient width in bits, signed.

Ports:
- iClk_12M  input  1  system clock, 12 MHz.
- iRst  input  1  synchronous reset, active-high.
- iStart  input  1  one-cycle pulse; begins sampling.
- iStop  input  1  one-cycle pulse; requests stop at the end of the current sample period.
- iCoeffWe  input  1  shadow-bank write strobe.
- iCoeffAddr  input  4  tap index to write, 0..NTAP-1.
- iCoeffData  input  CW  signed coefficient value.
- iCoeffCommit  input  1  one-cycle pulse; requests shadow-to-active copy.
- oCoeffBus  output  NTAP*CW  active bank; tap k occupies bits [k*CW +: CW]; drives datapath coefficients 1..NTAP.
- oEnSample_300k  output  1  one-cycle sample strobe.
- oEnAcc  output  1  one-cycle datapath accumulate enable.
- oMacValid  output  1  datapath output is valid for a single coefficient set.
- oCommitAck  output  1  one-cycle pulse on the cycle the active bank is updated.
- oCoeffErr  output  1  one-cycle pulse on a write to an out-of-range address.
- oBusy  output  1  high in RUN or STOPPING.

Behaviour:
- Reset: every output is 0. Shadow and active banks, sample counter, fill counter and commit-pending flag are cleared; state goes to IDLE. Assertion of iRst mid-operation takes effect at the next edge regardless of state.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE -> RUN on iStart. If iStart and iStop arrive in the same cycle, iStop wins and the FSM stays in IDLE.
  - RUN -> STOPPING on iStop. iStart is ignored in RUN.
  - STOPPING -> IDLE on the cycle the last strobe fires.
- Sample counter rCnt:
  - Range 0..DIV-1. Cleared to 0 on entry to RUN. Increments every cycle in RUN and STOPPING; wraps from DIV-1 to 0.
  - oEnSample_300k and oEnAcc are both asserted (registered) when rCnt == DIV-1, for exactly one cycle.
  - The first strobe is DIV cycles after the iStart cycle; the period is exactly DIV cycles.
  - In STOPPING, the final strobe of the current period still fires, then the FSM enters IDLE. No strobes are issued in IDLE.
- Shadow writes:
  - Accepted in any state when iCoeffAddr < NTAP.
  - iCoeffAddr >= NTAP: shadow bank is unchanged and oCoeffErr pulses on the next cycle.
- Commit:
  - iCoeffCommit sets the pending flag. A commit in the same cycle as a write includes that write's data.
  - Repeated commits while pending merge into a single swap and a single ack.
  - In IDLE: active <= shadow on the next edge, oCommitAck pulses, pending clears.
  - In RUN/STOPPING: the swap is deferred to the cycle with rCnt == 0 that follows a strobe, so all NTAP products of one strobe use a single bank.
  - A commit arriving in the same cycle as the swap cycle waits for the next period.
- Fill counter (0..NTAP+1, saturating):
  - Cleared on entry to RUN and on every active-bank swap.
  - Increments on each strobe.
  - oMacValid = 1 once the counter reaches NTAP+1 (the datapath's NTAP shift stages plus its output register), remaining 1 until the counter is cleared. It rises the cycle after the (NTAP+1)th strobe.
  - oMacValid stays 1 in IDLE after a stop (the held output is still valid); it clears on restart or on a swap.
- oBusy = (state != IDLE), registered.

Test Plan:
- Reset, then iStart at cycle 0 -> strobes at cycles 40, 80, 120; each oEnSample_300k/oEnAcc is high for exactly 1 cycle; oBusy = 1 from cycle 1.
- In IDLE, write taps 0..9 with values 1..10, then commit -> oCommitAck one cycle later; oCoeffBus[15:0] = 1 and oCoeffBus[159:144] = 10.
- Write to iCoeffAddr = 12 -> oCoeffErr pulses once; shadow bank unchanged (verify via a subsequent commit).
- In RUN, commit at rCnt = 5 -> oCoeffBus unchanged until rCnt = 0 after the next strobe; oCommitAck on that same cycle; oMacValid drops and returns 1 cycle after the 11th subsequent strobe.
- iStop at rCnt = 10 -> one more strobe at rCnt = 39, state IDLE the next cycle, no further strobes over 200 cycles; iStart together with iStop in IDLE -> FSM stays IDLE.
- iRst asserted at rCnt = 20 in RUN with a commit pending -> all outputs 0 next cycle, no ack, banks cleared, no strobes.
